// File: rtl/qc_ldpc_pkg.sv
// Shared definitions for the QC-LDPC encoder slice.
//   CIRC_DEFAULT : circulant size (bits per information block)
//   NBLK_DEFAULT : information blocks per codeword
//   seq_state_t  : sequencer FSM state encoding
//   idx_width()  : counter/address width for n items (never below 1 bit)
package qc_ldpc_pkg;

    localparam int unsigned CIRC_DEFAULT = 16;
    localparam int unsigned NBLK_DEFAULT = 4;

    typedef enum logic [2:0] {
        CLR     = 3'd0,
        COLLECT = 3'd1,
        FETCH   = 3'd2,
        LOAD    = 3'd3,
        ACCUM   = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/qc_enc_sequencer_if.sv
// Signal bundle between the encoder sequencer and its environment
// (information source, generator-row ROM, SRAA accumulator, parity sink).
//   info_in/info_valid/info_ready : serial information stream
//   gen_addr/gen_rd/gen_data      : generator ROM read (data one cycle after gen_rd)
//   gi_out/load_shift_reg         : row word and load strobe for the cyclic register
//   load_reg/info_bit/acc_clear   : accumulator controls
//   parity_valid/parity_ready     : parity word handshake
// Modports: master = sequencer side, slave = environment side.
interface qc_enc_sequencer_if
    import qc_ldpc_pkg::*;
#(
    parameter int unsigned CIRC = CIRC_DEFAULT,
    parameter int unsigned NBLK = NBLK_DEFAULT
);
    localparam int unsigned AW = idx_width(NBLK);

    logic            info_in;
    logic            info_valid;
    logic            info_ready;
    logic [AW-1:0]   gen_addr;
    logic            gen_rd;
    logic [CIRC-1:0] gen_data;
    logic [CIRC-1:0] gi_out;
    logic            load_shift_reg;
    logic            load_reg;
    logic            info_bit;
    logic            acc_clear;
    logic            parity_valid;
    logic            parity_ready;

    modport master (
        input  info_in, info_valid, gen_data, parity_ready,
        output info_ready, gen_addr, gen_rd, gi_out, load_shift_reg,
               load_reg, info_bit, acc_clear, parity_valid
    );

    modport slave (
        output info_in, info_valid, gen_data, parity_ready,
        input  info_ready, gen_addr, gen_rd, gi_out, load_shift_reg,
               load_reg, info_bit, acc_clear, parity_valid
    );

endinterface

// File: rtl/info_deser_16bit.sv
// Serial-in information block buffer with bit counter.
//   clk, clear : clock and synchronous active-high reset (zeroes buffer and counter)
//   bit_in     : serial information bit
//   accept     : store bit_in at data[bit_cnt] this cycle
//   data       : CIRC-bit block, data[0] is the first accepted bit
//   last       : the current accept completes the block (combinational)
module info_deser_16bit
    import qc_ldpc_pkg::*;
#(
    parameter int unsigned CIRC = CIRC_DEFAULT
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            bit_in,
    input  logic            accept,
    output logic [CIRC-1:0] data,
    output logic            last
);
    localparam int unsigned CW = idx_width(CIRC);
    localparam logic [CW-1:0] LAST_BIT = CW'(CIRC - 1);

    logic [CW-1:0] bit_cnt;

    assign last = accept && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (clear) begin
            data    <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            data[bit_cnt] <= bit_in;
            // Explicit wrap keeps non power-of-two CIRC in range.
            bit_cnt <= last ? '0 : bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/qc_enc_sequencer.sv
// QC-LDPC encoder sequencer. Collects CIRC serial information bits per
// block, fetches the block's generator first-row word, loads it into the
// external cyclic register and then drives CIRC contiguous AND-XOR
// accumulate cycles (LSB-first). After NBLK blocks it holds parity_valid
// until parity_ready, then clears the accumulator for the next codeword.
//   clk   : clock, all state changes on its rising edge
//   clear : synchronous active-high reset; also clears the accumulator
//   bus   : qc_enc_sequencer_if master modport (stream, ROM, accumulator, parity)
module qc_enc_sequencer
    import qc_ldpc_pkg::*;
#(
    parameter int unsigned CIRC = CIRC_DEFAULT,
    parameter int unsigned NBLK = NBLK_DEFAULT
) (
    input  logic                clk,
    input  logic                clear,
    qc_enc_sequencer_if.master  bus
);
    localparam int unsigned CW = idx_width(CIRC);
    localparam int unsigned AW = idx_width(NBLK);
    localparam logic [CW-1:0] LAST_BIT = CW'(CIRC - 1);
    localparam logic [AW-1:0] LAST_BLK = AW'(NBLK - 1);

    seq_state_t      state;
    logic [AW-1:0]   blk_cnt;
    logic [CW-1:0]   acc_cnt;
    logic [CW-1:0]   next_idx;
    logic [CIRC-1:0] info_buf;
    logic            accept;
    logic            blk_full;

    // Registered outputs, computed from the state being entered.
    logic            info_ready_q;
    logic            gen_rd_q;
    logic [AW-1:0]   gen_addr_q;
    logic            load_shift_reg_q;
    logic            load_reg_q;
    logic            info_bit_q;
    logic            acc_clear_q;
    logic            parity_valid_q;

    assign accept   = bus.info_valid & info_ready_q;
    assign next_idx = acc_cnt + CW'(1);

    info_deser_16bit #(
        .CIRC (CIRC)
    ) u_deser (
        .clk    (clk),
        .clear  (clear),
        .bit_in (bus.info_in),
        .accept (accept),
        .data   (info_buf),
        .last   (blk_full)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state            <= CLR;
            blk_cnt          <= '0;
            acc_cnt          <= '0;
            info_ready_q     <= 1'b0;
            gen_rd_q         <= 1'b0;
            gen_addr_q       <= '0;
            load_shift_reg_q <= 1'b0;
            load_reg_q       <= 1'b0;
            info_bit_q       <= 1'b0;
            acc_clear_q      <= 1'b1;
            parity_valid_q   <= 1'b0;
        end else begin
            // Single-cycle strobes fall unless the transition below re-asserts them.
            gen_rd_q         <= 1'b0;
            gen_addr_q       <= '0;
            load_shift_reg_q <= 1'b0;
            acc_clear_q      <= 1'b0;

            case (state)
                CLR: begin
                    blk_cnt      <= '0;
                    info_ready_q <= 1'b1;
                    state        <= COLLECT;
                end

                COLLECT: begin
                    if (blk_full) begin
                        info_ready_q <= 1'b0;
                        gen_rd_q     <= 1'b1;
                        gen_addr_q   <= blk_cnt;
                        state        <= FETCH;
                    end
                end

                FETCH: begin
                    load_shift_reg_q <= 1'b1;
                    state            <= LOAD;
                end

                LOAD: begin
                    acc_cnt    <= '0;
                    load_reg_q <= 1'b1;
                    info_bit_q <= info_buf[0];
                    state      <= ACCUM;
                end

                ACCUM: begin
                    if (acc_cnt == LAST_BIT) begin
                        acc_cnt    <= '0;
                        load_reg_q <= 1'b0;
                        info_bit_q <= 1'b0;
                        if (blk_cnt < LAST_BLK) begin
                            blk_cnt      <= blk_cnt + AW'(1);
                            info_ready_q <= 1'b1;
                            state        <= COLLECT;
                        end else begin
                            parity_valid_q <= 1'b1;
                            state          <= DONE;
                        end
                    end else begin
                        // info_bit is registered, so look one index ahead.
                        acc_cnt    <= next_idx;
                        info_bit_q <= info_buf[next_idx];
                    end
                end

                DONE: begin
                    if (bus.parity_ready) begin
                        parity_valid_q <= 1'b0;
                        acc_clear_q    <= 1'b1;
                        state          <= CLR;
                    end
                end

                default: begin
                    info_ready_q   <= 1'b0;
                    load_reg_q     <= 1'b0;
                    info_bit_q     <= 1'b0;
                    parity_valid_q <= 1'b0;
                    acc_clear_q    <= 1'b1;
                    state          <= CLR;
                end
            endcase
        end
    end

    assign bus.info_ready     = info_ready_q;
    assign bus.gen_rd         = gen_rd_q;
    assign bus.gen_addr       = gen_addr_q;
    assign bus.load_shift_reg = load_shift_reg_q;
    assign bus.load_reg       = load_reg_q;
    assign bus.info_bit       = info_bit_q;
    assign bus.acc_clear      = acc_clear_q;
    assign bus.parity_valid   = parity_valid_q;

    // ROM data only arrives during LOAD, so the row word is passed straight through.
    assign bus.gi_out = (state == LOAD) ? bus.gen_data : '0;

endmodule

// File: tb/tb_qc_enc_sequencer.sv
// Testbench for qc_enc_sequencer: generator ROM and SRAA accumulator models
// around the DUT, a golden parity model, and a scoreboard monitor.
`timescale 1ns/1ps
module tb_qc_enc_sequencer;
    import qc_ldpc_pkg::*;

    localparam int unsigned CIRC   = 16;
    localparam int unsigned NBLK   = 4;
    localparam int unsigned K      = CIRC * NBLK;
    localparam int          BUDGET = 3000;

    typedef struct {
        int              pv_cyc;
        int              n_ready;
        int              n_rd;
        int              n_lsr;
        int              n_lr;
        int              n_ac;
        int              ready_blk0;
        logic [CIRC-1:0] acc0_bits;
        int              acc0_len;
        int              addr0;
    } obs_t;

    logic clk = 1'b0;
    logic clear = 1'b1;
    bit   abort = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    obs_t obs;

    logic [CIRC-1:0] rom [NBLK];
    logic [CIRC-1:0] sraa_shreg;
    logic [CIRC-1:0] sraa_par;
    bit              exp_bits [$];
    logic [CIRC-1:0] par_q [$];

    qc_enc_sequencer_if #(.CIRC(CIRC), .NBLK(NBLK)) bus ();

    qc_enc_sequencer #(.CIRC(CIRC), .NBLK(NBLK)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Generator ROM: first-row word one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.gen_rd) bus.gen_data <= rom[bus.gen_addr];
    end

    // SRAA accumulator: cyclic register rotates unless loaded; AND-XOR into parity.
    always @(posedge clk) begin
        if (bus.load_shift_reg) sraa_shreg <= bus.gi_out;
        else                    sraa_shreg <= {sraa_shreg[CIRC-2:0], sraa_shreg[CIRC-1]};
        if (bus.acc_clear)                      sraa_par <= '0;
        else if (bus.load_reg && bus.info_bit)  sraa_par <= sraa_par ^ sraa_shreg;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Parity = XOR of row j of each block's circulant (row j = row 0 rotated
    // left by j) over every set message bit.
    function automatic logic [CIRC-1:0] golden(input logic [K-1:0] m);
        logic [CIRC-1:0] p;
        logic [CIRC-1:0] g;
        p = '0;
        for (int b = 0; b < NBLK; b++) begin
            g = rom[b];
            for (int j = 0; j < CIRC; j++) begin
                if (m[b*CIRC + j]) p = p ^ g;
                g = {g[CIRC-2:0], g[CIRC-1]};
            end
        end
        return p;
    endfunction

    // Scoreboard monitor.
    bit prev_pv;
    bit prev_rd;
    int rd_addr;
    int run_len;
    int exp_blk;
    always @(negedge clk) begin
        if (clear) begin
            prev_pv = 1'b0;
            prev_rd = 1'b0;
            run_len = 0;
            exp_blk = 0;
        end else begin
            check("strobe_exclusive", 64'($countones({bus.info_ready, bus.gen_rd, bus.load_shift_reg,
                  bus.load_reg, bus.acc_clear, bus.parity_valid}) <= 1), 64'd1);
            check("info_bit_gated", 64'(bus.info_bit & ~bus.load_reg), 64'd0);
            if (!bus.load_shift_reg) check("gi_out_idle", 64'(bus.gi_out), 64'd0);
            if (bus.gen_rd) begin
                check("gen_addr", 64'(bus.gen_addr), 64'(exp_blk));
                rd_addr = int'(bus.gen_addr);
                exp_blk = (exp_blk + 1) % NBLK;
            end
            if (bus.load_shift_reg) begin
                check("fetch_before_load", 64'(prev_rd), 64'd1);
                check("gi_out_load", 64'(bus.gi_out), 64'(rom[rd_addr]));
            end
            if (bus.load_reg) begin
                run_len++;
                check("bits_queued", 64'(exp_bits.size() > 0), 64'd1);
                if (exp_bits.size() > 0) check("info_bit", 64'(bus.info_bit), 64'(exp_bits.pop_front()));
            end else if (run_len != 0) begin
                check("accum_len", 64'(run_len), 64'(CIRC));
                run_len = 0;
            end
            if (bus.parity_valid && !prev_pv) begin
                check("parity_queued", 64'(par_q.size() > 0), 64'd1);
                if (par_q.size() > 0) check("parity", 64'(sraa_par), 64'(par_q.pop_front()));
            end
            prev_pv = bus.parity_valid;
            prev_rd = bus.gen_rd;
        end
    end

    // mode 0: continuous valid; 1: valid toggles starting high; other: random gaps.
    task automatic drive_msg(input logic [K-1:0] msg, input int mode);
        int i = 0;
        int cyc = 0;
        bit v;
        bit acc;
        while (i < K && !abort) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.info_valid = v;
            bus.info_in    = v ? msg[i] : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = v && bus.info_ready;
            if (acc) exp_bits.push_back(msg[i]);
            @(posedge clk);
            #1;
            if (acc) i++;
            cyc++;
            if (cyc > BUDGET) begin
                check("drive_budget", 64'(cyc), 64'(BUDGET));
                break;
            end
        end
        bus.info_valid = 1'b0;
    endtask

    // Cycle 0 is the CLR cycle in which the caller starts.
    task automatic observe();
        bit seen_rd = 1'b0;
        bit acc0_done = 1'b0;
        obs = '{default: 0};
        obs.pv_cyc = -1;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (bus.info_ready) begin
                obs.n_ready++;
                if (!seen_rd) obs.ready_blk0++;
            end
            if (bus.gen_rd) begin
                if (!seen_rd) obs.addr0 = int'(bus.gen_addr);
                seen_rd = 1'b1;
                obs.n_rd++;
            end
            if (bus.load_shift_reg) obs.n_lsr++;
            if (bus.acc_clear) obs.n_ac++;
            if (bus.load_reg) begin
                obs.n_lr++;
                if (!acc0_done) begin
                    if (obs.acc0_len < CIRC) obs.acc0_bits[obs.acc0_len] = bus.info_bit;
                    obs.acc0_len++;
                end
            end else if (obs.acc0_len > 0) begin
                acc0_done = 1'b1;
            end
            if (bus.parity_valid) begin
                obs.pv_cyc = c;
                break;
            end
        end
        check("pv_within_budget", 64'(obs.pv_cyc >= 0), 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_bits.delete();
        par_q.delete();
        clear = 1'b0;
    endtask

    task automatic run_msg(input logic [K-1:0] msg, input int mode);
        do_reset();
        par_q.push_back(golden(msg));
        fork
            drive_msg(msg, mode);
            observe();
        join
    endtask

    // Entered at the first parity_valid negedge.
    task automatic handshake(input int hold);
        int held = 0;
        for (int d = 0; d < hold; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.parity_valid) held++;
        end
        check("pv_held", 64'(held), 64'(hold));
        @(posedge clk); #1; bus.parity_ready = 1'b1;
        @(posedge clk); #1; bus.parity_ready = 1'b0;
        @(negedge clk);
        check("ack_clears", 64'({bus.acc_clear, bus.parity_valid}), 64'(2'b10));
        @(negedge clk);
        check("acc_clear_once", 64'({bus.acc_clear, bus.info_ready}), 64'(2'b01));
    endtask

    logic [K-1:0] m;

    initial begin
        bus.info_valid   = 1'b0;
        bus.info_in      = 1'b0;
        bus.parity_ready = 1'b0;
        for (int b = 0; b < NBLK; b++) rom[b] = CIRC'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 64'({bus.acc_clear, bus.info_ready, bus.gen_rd, bus.load_shift_reg,
              bus.load_reg, bus.info_bit, bus.parity_valid}), 64'(7'b1000000));
        check("reset_gi_out", 64'(bus.gi_out), 64'd0);

        // All-ones message, continuous valid.
        run_msg('1, 0);
        check("ones_pv_cycle", 64'(obs.pv_cyc), 64'(1 + NBLK * (2*CIRC + 2)));
        check("ones_info_ready", 64'(obs.n_ready), 64'(K));
        check("ones_gen_rd", 64'(obs.n_rd), 64'(NBLK));
        check("ones_load_shift", 64'(obs.n_lsr), 64'(NBLK));
        check("ones_load_reg", 64'(obs.n_lr), 64'(K));
        check("ones_acc_clear", 64'(obs.n_ac), 64'd1);
        handshake(10);

        // Block 0 = 0x0001: info_bit only in the first accumulate cycle.
        m = K'({$urandom, $urandom});
        m[CIRC-1:0] = CIRC'(1);
        run_msg(m, 0);
        check("lsb_acc0_bits", 64'(obs.acc0_bits), 64'd1);
        check("lsb_acc0_len", 64'(obs.acc0_len), 64'(CIRC));
        handshake(0);

        // Alternating valid: 2*CIRC collect cycles per block, accumulate still contiguous.
        m = K'({$urandom, $urandom});
        run_msg(m, 1);
        check("toggle_ready_blk0", 64'(obs.ready_blk0), 64'(2*CIRC));
        check("toggle_acc0_len", 64'(obs.acc0_len), 64'(CIRC));
        check("toggle_pv_cycle", 64'(obs.pv_cyc), 64'(1 + NBLK * (3*CIRC + 2)));
        handshake(3);

        // clear during accumulate cycle 7 of block 2, then a fresh codeword.
        do_reset();
        m = K'({$urandom, $urandom});
        par_q.push_back(golden(m));
        fork
            drive_msg(m, 0);
            begin
                for (int c = 0; c < 1 + 2*(2*CIRC + 2) + CIRC + 2 + 6; c++) @(negedge clk);
                @(posedge clk); #1; clear = 1'b1;
                @(negedge clk);
                check("abort_in_accum", 64'(bus.load_reg), 64'd1);
                abort = 1'b1;
                @(negedge clk);
                check("abort_clr", 64'({bus.acc_clear, bus.load_reg, bus.info_ready, bus.parity_valid}),
                      64'(4'b1000));
                @(posedge clk); #1; clear = 1'b0;
            end
        join
        abort = 1'b0;
        exp_bits.delete();
        par_q.delete();
        m = K'({$urandom, $urandom});
        par_q.push_back(golden(m));
        fork
            drive_msg(m, 0);
            observe();
        join
        check("restart_addr0", 64'(obs.addr0), 64'd0);
        check("restart_pv_cycle", 64'(obs.pv_cyc), 64'(1 + NBLK * (2*CIRC + 2)));
        handshake(2);

        // Random messages, random ROM, random valid gaps and ready delays.
        for (int t = 0; t < 20; t++) begin
            for (int b = 0; b < NBLK; b++) rom[b] = CIRC'($urandom);
            m = K'({$urandom, $urandom});
            run_msg(m, 2);
            check("rand_acc0_len", 64'(obs.acc0_len), 64'(CIRC));
            handshake(int'($urandom_range(0, 5)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qc_enc_sequencer.md
QC_ENC_SEQUENCER -- requirements
Module: qc_enc_sequencer

Interface
REQ-001 SHALL have parameter CIRC, default 16: circulant size, bits per information block.
REQ-002 SHALL have parameter NBLK, default 4: information blocks per codeword (k = CIRC*NBLK).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port info_in, input, 1: serial information bit.
REQ-006 SHALL have port info_valid, input, 1: info_in is valid.
REQ-007 SHALL have port info_ready, output, 1: sequencer accepts info_in this cycle.
REQ-008 SHALL have port gen_addr, output, clog2(NBLK): generator-row ROM address (block index).
REQ-009 SHALL have port gen_rd, output, 1: ROM read strobe.
REQ-010 SHALL have port gen_data, input, CIRC: ROM first-row word, valid the cycle after gen_rd.
REQ-011 SHALL have port gi_out, output, CIRC: row word driven to the accumulator's cyclic register.
REQ-012 SHALL have port load_shift_reg, output, 1: load gi_out into the cyclic register (low = rotate).
REQ-013 SHALL have port load_reg, output, 1: accumulate enable for the parity register.
REQ-014 SHALL have port info_bit, output, 1: bit applied to the AND-XOR accumulate.
REQ-015 SHALL have port acc_clear, output, 1: clears the parity accumulator.
REQ-016 SHALL have port parity_valid, output, 1: the accumulator holds the final parity word.
REQ-017 SHALL have port parity_ready, input, 1: downstream has taken the parity word.

Function
REQ-018 SHALL implement FSM states CLR, COLLECT, FETCH, LOAD, ACCUM, DONE.
REQ-019 CLR SHALL assert acc_clear for exactly 1 cycle, zero the block counter, then enter COLLECT.
REQ-020 COLLECT SHALL assert info_ready; each info_valid&info_ready cycle SHALL store info_in into buf[bit_cnt], bit_cnt+1.
REQ-021 After the CIRC-th accepted bit, the FSM SHALL enter FETCH; info_ready SHALL be low in every state except COLLECT.
REQ-022 FETCH SHALL assert gen_rd for 1 cycle with gen_addr = blk_cnt.
REQ-023 LOAD SHALL assert load_shift_reg for 1 cycle with gi_out = gen_data; load_reg SHALL be low.
REQ-024 ACCUM SHALL last exactly CIRC cycles; cycle j (0..CIRC-1) SHALL drive load_reg=1, load_shift_reg=0, info_bit=buf[j].
REQ-025 The first bit accepted in a block SHALL be the first bit accumulated (LSB-first).
REQ-026 After ACCUM: if blk_cnt < NBLK-1, then blk_cnt+1 and go to COLLECT; else go to DONE.
REQ-027 DONE SHALL hold parity_valid=1 with load_reg=0 and acc_clear=0 until parity_ready=1, then go to CLR.
REQ-028 parity_valid SHALL rise the cycle after the last load_reg cycle.
REQ-029 Minimum cycles per block SHALL be CIRC+CIRC+2 (collect, fetch, load, accumulate).
REQ-030 info_valid gaps during COLLECT SHALL stall bit_cnt only; no bubble SHALL occur inside ACCUM.
REQ-031 info_valid while info_ready=0 SHALL be ignored; that bit SHALL NOT be consumed.
REQ-032 In every state other than the one named, outputs SHALL be 0: gen_rd, load_shift_reg, load_reg, info_bit, acc_clear, parity_valid.
REQ-033 gi_out SHALL be 0 outside LOAD.

Reset
REQ-034 clear=1 SHALL force the next state to CLR, and bit_cnt, blk_cnt and buf to 0, regardless of the current state.
REQ-035 While clear=1, acc_clear SHALL be 1 and all other outputs 0, so the accumulator is cleared together with the sequencer.
REQ-036 A reset during ACCUM or DONE SHALL discard the partial codeword; no parity_valid SHALL follow for that codeword.

Structure
REQ-037 Shared package qc_ldpc_pkg SHALL hold CIRC, NBLK defaults and the FSM state encoding.
REQ-038 One sub-module, info_deser_16bit (CIRC-bit serial-in buffer with bit counter), SHALL be used; the FSM and counters SHALL be in the top level.

Verification
REQ-039 Reset, then 64 bits of all-ones with info_valid=1 continuously -> 4 blocks; each block shows 16 info_ready, 1 gen_rd, 1 load_shift_reg and 16 load_reg cycles; parity_valid at cycle 1+4*34.
REQ-040 Block 0 with bits 0x0001 (LSB first) -> info_bit=1 only in ACCUM cycle 0.
REQ-041 info_valid toggling 1/0 in COLLECT -> 32 cycles to fill the block; the ACCUM window is still 16 contiguous cycles.
REQ-042 parity_ready held low for 10 cycles in DONE -> parity_valid stays 1 for 10 cycles; acc_clear pulses once after the handshake.
REQ-043 clear asserted at ACCUM cycle 7 of block 2 -> the next cycle is CLR with acc_clear=1; the new codeword starts at blk_cnt=0.
REQ-044 Against the SRAA_16BIT accumulator plus a golden generator model, 20 random messages -> parity word matches on every parity_valid.
